dmem_store_queue_arbiter: RTL and testbench
===========================================

Name: dmem_store_queue_arbiter

Overview:
- Sits between the out-of-order datapath's load/store units and the data memory.
- Buffers ROB-committed stores in an in-order queue and arbitrates the one shared memory access slot per cycle between loads and store drains.
- Forwards queued store data to matching loads so that loads never observe stale memory.

Parameters:
DEPTH, 4, number of store-queue entries (power of two, at least 2)
MAX_WAIT, 8, cycles a head store may be denied before a drain is forced

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
st_valid_i  in  1  committed store request
st_addr_i  in  64  store doubleword address
st_data_i  in  64  store data
st_ready_o  out  1  queue can accept a store this cycle
ld_valid_i  in  1  load request
ld_addr_i  in  64  load doubleword address
ld_ready_o  out  1  load accepted this cycle
ld_done_o  out  1  load data valid (one cycle after accept)
ld_data_o  out  64  load result
dmem_readData  in  64  memory read data, valid the cycle after dmem_readEn
dmem_addressLoad  out  64  memory load address
dmem_addressStore  out  64  memory store address
dmem_WriteData  out  64  memory write data
dmem_readEn  out  1  memory read strobe
dmem_writeEn  out  1  memory write strobe

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. All state updates on the posedge of clk.
- Reset values: queue empty, head, tail and count at 0, wait counter at 0. st_ready_o=1, ld_ready_o=1, ld_done_o=0, ld_data_o=0, dmem_readEn=0, dmem_writeEn=0, all dmem address/data outputs 0.
- Reset mid-operation: queued stores are discarded. An in-flight load produces no ld_done_o.
- Memory rule: dmem_readEn and dmem_writeEn are never high in the same cycle.
- Enqueue:
  - Handshake is st_valid_i && st_ready_o. st_ready_o = (count != DEPTH), derived from registered count only. There is no same-cycle bypass from a drain.
  - The new entry is written at tail, and tail wraps modulo DEPTH.
- Forward check on each load request:
  - All valid entries present at cycle start are compared on the full 64-bit address. Entries enqueued in the same cycle are excluded.
  - If several entries match, the youngest one (nearest tail) wins.
- Arbitration, evaluated each cycle in priority order:
  1. Forced drain: the queue is full, or the wait counter has reached MAX_WAIT. The head store drains, ld_ready_o=0, and no load is accepted.
  2. Load with forward hit: ld_ready_o=1 and no memory read is issued. The head store may drain in the same cycle. The head entry is still counted as a forward source.
  3. Load with forward miss: ld_ready_o=1 and dmem_readEn=1 with dmem_addressLoad=ld_addr_i. No drain occurs.
  4. No load: the head store drains if the queue is non-empty.
- Drain: dmem_writeEn=1 with the head entry's address and data. Head advances modulo DEPTH and count decrements.
  - If an enqueue and a drain happen in the same cycle, count is unchanged.
- Wait counter:
  - Increments on each cycle the queue is non-empty and the head is not drained.
  - Clears on any drain or when the queue is empty.
  - Saturates at MAX_WAIT.
- Load latency: exactly 1 cycle. ld_done_o is registered high in the cycle after acceptance.
  - On a forward hit, ld_data_o is the registered forwarded data.
  - On a miss, ld_data_o = dmem_readData.
  - ld_data_o holds its value otherwise.
- Ordering: stores reach memory in commit order. A load accepted after a store is enqueued always sees that store's data, either by forwarding or because the store has already drained.
- When ld_ready_o=0, the requester holds ld_valid_i and ld_addr_i stable until accepted.

Decomposition:
- Package dmem_sq_pkg holds:
  - sq_entry_t struct: valid, addr[63:0], data[63:0].
  - Pointer width constant, $clog2(DEPTH).
  - Arbitration-outcome enum: ARB_IDLE, ARB_FORCE_DRAIN, ARB_LD_FWD, ARB_LD_MEM, ARB_DRAIN.
- Sub-module sq_youngest_match: combinational search from tail-1 backwards to head. Outputs hit and the matching data.

Test Plan:
1. Reset, then load 0x40 with empty queue → dmem_readEn=1, dmem_addressLoad=0x40 in cycle t; ld_done_o=1 with ld_data_o=mem[0x40] in t+1; dmem_writeEn stays 0.
2. Enqueue store 0x80←0xAA then store 0x80←0xBB, then load 0x80 while both are queued → ld_done_o with ld_data_o=0xBB; no dmem_readEn; the drain of 0xAA occurs in the load cycle.
3. Enqueue 4 stores with loads to other addresses every cycle → st_ready_o=0 at count=4; next cycle forced drain with ld_ready_o=0; st_ready_o returns to 1 the following cycle.
4. One queued store plus continuous missing loads → the store waits exactly 8 cycles, then a forced drain with ld_ready_o=0 for that one cycle.
5. Store to 0x100 enqueued in the same cycle as a load to 0x100 → the load reads memory (not forwarded); the store drains afterwards; a later load to 0x100 returns the store data.
6. Assert reset with 3 queued stores and a load in flight → next cycle ld_done_o=0, st_ready_o=1, and no dmem_writeEn from the discarded entries.

Source files
------------

// File: rtl/dmem_store_queue_arbiter_pkg.sv
// Purpose: shared types and constants for the data-memory store queue / arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: sq_entry_t queue entry, default depth/wait limit, pointer-width helper,
//           arbitration-outcome enum.
package dmem_sq_pkg;

  localparam int SQ_DEPTH    = 4;
  localparam int SQ_MAX_WAIT = 8;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [63:0] data;
  } sq_entry_t;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_FORCE_DRAIN,
    ARB_LD_FWD,
    ARB_LD_MEM,
    ARB_DRAIN
  } arb_e;

  function automatic int sq_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int SQ_PTR_W = sq_ptr_w(SQ_DEPTH);

endpackage

// File: rtl/dmem_store_queue_arbiter_if.sv
// Purpose: bundles the store, load and data-memory signals of the store-queue arbiter.
// Latency: n/a (wiring only).
// Backpressure: st_ready_o / ld_ready_o flow from the arbiter back to the requesters.
// Modports: slave = the arbiter itself, master = datapath + memory environment.
interface dmem_sq_if;
  logic        st_valid_i;
  logic [63:0] st_addr_i;
  logic [63:0] st_data_i;
  logic        st_ready_o;
  logic        ld_valid_i;
  logic [63:0] ld_addr_i;
  logic        ld_ready_o;
  logic        ld_done_o;
  logic [63:0] ld_data_o;
  logic [63:0] dmem_readData;
  logic [63:0] dmem_addressLoad;
  logic [63:0] dmem_addressStore;
  logic [63:0] dmem_WriteData;
  logic        dmem_readEn;
  logic        dmem_writeEn;

  modport slave (
    input  st_valid_i, st_addr_i, st_data_i, ld_valid_i, ld_addr_i, dmem_readData,
    output st_ready_o, ld_ready_o, ld_done_o, ld_data_o,
           dmem_addressLoad, dmem_addressStore, dmem_WriteData, dmem_readEn, dmem_writeEn
  );

  modport master (
    output st_valid_i, st_addr_i, st_data_i, ld_valid_i, ld_addr_i, dmem_readData,
    input  st_ready_o, ld_ready_o, ld_done_o, ld_data_o,
           dmem_addressLoad, dmem_addressStore, dmem_WriteData, dmem_readEn, dmem_writeEn
  );
endinterface

// File: rtl/dmem_store_queue_arbiter_match.sv
// Purpose: finds the youngest valid store-queue entry whose address equals the load address.
// Latency: combinational.
// Backpressure: none.
// Ports: entries_i (queue contents), tail_i (next write slot), addr_i (load address),
//        hit_o / data_o (match found and its store data).
module sq_youngest_match
  import dmem_sq_pkg::*;
#(
  parameter int DEPTH = SQ_DEPTH,
  parameter int PTR_W = SQ_PTR_W
) (
  input  sq_entry_t         entries_i [DEPTH],
  input  logic [PTR_W-1:0]  tail_i,
  input  logic [63:0]       addr_i,
  output logic              hit_o,
  output logic [63:0]       data_o
);

  logic [PTR_W-1:0] idx;

  // Walk from tail-1 back towards head; the first hit is the youngest store.
  // Only live entries carry valid, so the walk needs no explicit head bound.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = tail_i - PTR_W'(i + 1);
      if (!hit_o && entries_i[idx].valid && (entries_i[idx].addr == addr_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/dmem_store_queue_arbiter.sv
// Purpose: in-order committed-store queue with load forwarding, sharing one dmem slot per cycle.
// Latency: load data 1 cycle after acceptance; stores drain in commit order when the slot is free.
// Backpressure: st_ready_o low when full; ld_ready_o low only on a forced head drain.
// Ports: clk, reset (sync, active-high), bus (dmem_sq_if.slave: store req, load req/resp, dmem).
module dmem_store_queue_arbiter
  import dmem_sq_pkg::*;
#(
  parameter int DEPTH    = SQ_DEPTH,
  parameter int MAX_WAIT = SQ_MAX_WAIT
) (
  input logic      clk,
  input logic      reset,
  dmem_sq_if.slave bus
);

  localparam int PTR_W  = sq_ptr_w(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  sq_entry_t         sq_q [DEPTH];
  sq_entry_t         sq_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              ld_done_q, ld_done_d;
  logic              ld_miss_q, ld_miss_d;
  logic [63:0]       ld_data_q, ld_data_d;

  arb_e        arb;
  logic        fwd_hit;
  logic [63:0] fwd_data;
  logic        empty, full, force_drain, enq, drain;

  // Search uses registered entries only, so a store enqueued this cycle never forwards.
  sq_youngest_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match (
    .entries_i (sq_q),
    .tail_i    (tail_q),
    .addr_i    (bus.ld_addr_i),
    .hit_o     (fwd_hit),
    .data_o    (fwd_data)
  );

  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_W'(DEPTH));
  assign force_drain = full || (wait_q == WAIT_W'(MAX_WAIT));
  assign enq         = bus.st_valid_i && !full;

  always_comb begin
    arb = ARB_IDLE;
    if (force_drain)                  arb = ARB_FORCE_DRAIN;
    else if (bus.ld_valid_i && fwd_hit) arb = ARB_LD_FWD;
    else if (bus.ld_valid_i)          arb = ARB_LD_MEM;
    else if (!empty)                  arb = ARB_DRAIN;
  end

  // A forwarded load leaves the memory slot free, so the head drains alongside it.
  assign drain = !empty && (arb inside {ARB_FORCE_DRAIN, ARB_LD_FWD, ARB_DRAIN});

  assign bus.st_ready_o        = !full;
  assign bus.ld_ready_o        = !force_drain;
  assign bus.dmem_readEn       = (arb == ARB_LD_MEM);
  assign bus.dmem_addressLoad  = (arb == ARB_LD_MEM) ? bus.ld_addr_i : '0;
  assign bus.dmem_writeEn      = drain;
  assign bus.dmem_addressStore = drain ? sq_q[head_q].addr : '0;
  assign bus.dmem_WriteData    = drain ? sq_q[head_q].data : '0;
  assign bus.ld_done_o         = ld_done_q;
  // Memory data arrives unregistered in the done cycle, then is held in ld_data_q.
  assign bus.ld_data_o         = (ld_done_q && ld_miss_q) ? bus.dmem_readData : ld_data_q;

  always_comb begin
    sq_d      = sq_q;
    head_d    = head_q;
    tail_d    = tail_q;
    wait_d    = wait_q;
    ld_done_d = 1'b0;
    ld_miss_d = 1'b0;
    ld_data_d = ld_data_q;

    if (ld_done_q && ld_miss_q) ld_data_d = bus.dmem_readData;
    if (arb == ARB_LD_FWD) begin
      ld_done_d = 1'b1;
      ld_data_d = fwd_data;
    end
    if (arb == ARB_LD_MEM) begin
      ld_done_d = 1'b1;
      ld_miss_d = 1'b1;
    end

    // head == tail only when empty or full, so drain and enqueue never hit the same slot.
    if (drain) begin
      sq_d[head_q].valid = 1'b0;
      head_d             = head_q + PTR_W'(1);
    end
    if (enq) begin
      sq_d[tail_q] = '{valid: 1'b1, addr: bus.st_addr_i, data: bus.st_data_i};
      tail_d       = tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(enq) - CNT_W'(drain);

    if (drain || empty)                      wait_d = '0;
    else if (wait_q != WAIT_W'(MAX_WAIT))    wait_d = wait_q + WAIT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) sq_q[i] <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wait_q    <= '0;
      ld_done_q <= 1'b0;
      ld_miss_q <= 1'b0;
      ld_data_q <= '0;
    end else begin
      sq_q      <= sq_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      wait_q    <= wait_d;
      ld_done_q <= ld_done_d;
      ld_miss_q <= ld_miss_d;
      ld_data_q <= ld_data_d;
    end
  end

endmodule

// File: tb/tb_dmem_store_queue_arbiter.sv
module tb_dmem_store_queue_arbiter;
  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_sq_if bus();

  dmem_store_queue_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] init_val(input logic [63:0] a);
    return 64'h1000_0000_0000_0000 | a;
  endfunction

  // ---------------- memory environment ----------------
  logic [63:0] env_mem [logic [63:0]];
  always @(posedge clk) begin
    if (bus.dmem_readEn)
      bus.dmem_readData <= env_mem.exists(bus.dmem_addressLoad) ?
                           env_mem[bus.dmem_addressLoad] : init_val(bus.dmem_addressLoad);
    if (bus.dmem_writeEn && !reset)
      env_mem[bus.dmem_addressStore] = bus.dmem_WriteData;
  end

  // ---------------- behavioural reference ----------------
  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } st_t;

  st_t         m_q[$];
  logic [63:0] m_mem [logic [63:0]];
  int          m_wait = 0;
  bit          m_pend = 0;
  logic [63:0] m_pend_val = '0;
  logic [63:0] m_last = '0;
  bit          m_ok = 0;

  function automatic logic [63:0] m_rd(input logic [63:0] a);
    return m_mem.exists(a) ? m_mem[a] : init_val(a);
  endfunction

  task automatic model_step();
    int          n;
    bit          frc, hit, acc, rd, drn;
    logic [63:0] fwd;
    n   = m_q.size();
    frc = (n == DEPTH) || (m_wait >= MAX_WAIT);
    hit = 0;
    fwd = '0;
    for (int i = n - 1; i >= 0; i--)
      if (!hit && m_q[i].addr == bus.ld_addr_i) begin
        hit = 1;
        fwd = m_q[i].data;
      end
    acc = bus.ld_valid_i && !frc;
    rd  = acc && !hit;
    drn = (n > 0) && (frc || (acc && hit) || !bus.ld_valid_i);

    chk1 ("st_ready",  bus.st_ready_o,  n != DEPTH);
    chk1 ("ld_ready",  bus.ld_ready_o,  !frc);
    chk1 ("readEn",    bus.dmem_readEn, rd);
    chk64("addrLoad",  bus.dmem_addressLoad, rd ? bus.ld_addr_i : 64'h0);
    chk1 ("writeEn",   bus.dmem_writeEn, drn);
    chk64("addrStore", bus.dmem_addressStore, drn ? m_q[0].addr : 64'h0);
    chk64("wdata",     bus.dmem_WriteData, drn ? m_q[0].data : 64'h0);
    chk1 ("ld_done",   bus.ld_done_o, m_pend);
    chk64("ld_data",   bus.ld_data_o, m_pend ? m_pend_val : m_last);

    if (m_pend) m_last = m_pend_val;
    m_pend = acc;
    if (acc) m_pend_val = hit ? fwd : m_rd(bus.ld_addr_i);
    if (drn) begin
      m_mem[m_q[0].addr] = m_q[0].data;
      void'(m_q.pop_front());
    end
    if (bus.st_valid_i && n != DEPTH) m_q.push_back('{addr: bus.st_addr_i, data: bus.st_data_i});
    if (drn || n == 0) m_wait = 0;
    else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      m_q.delete();
      m_wait = 0;
      m_pend = 0;
      m_last = '0;
      m_ok   = 1;
    end else if (m_ok) begin
      model_step();
    end
  end

  // ---------------- stimulus ----------------
  bit prev_rdy = 1;

  task automatic cyc(input bit rst, input bit sv, input logic [63:0] sa, input logic [63:0] sd,
                     input bit lv, input logic [63:0] la);
    @(posedge clk);
    #1;
    reset          = rst;
    bus.st_valid_i = sv;
    bus.st_addr_i  = sa;
    bus.st_data_i  = sd;
    bus.ld_valid_i = lv;
    bus.ld_addr_i  = la;
    #4;
    prev_rdy = bus.ld_ready_o;
  endtask

  task automatic idle();
    cyc(0, 0, 64'h0, 64'h0, 0, 64'h0);
  endtask

  initial begin
    bit          r, sv, lv;
    logic [63:0] sa, sd, la;
    bus.st_valid_i = 0; bus.st_addr_i = '0; bus.st_data_i = '0;
    bus.ld_valid_i = 0; bus.ld_addr_i = '0;

    cyc(1, 0, 64'h0, 64'h0, 0, 64'h0);
    cyc(1, 0, 64'h0, 64'h0, 0, 64'h0);

    // reset state
    idle();
    chk1 ("rst_st_ready", bus.st_ready_o, 1'b1);
    chk1 ("rst_ld_ready", bus.ld_ready_o, 1'b1);
    chk1 ("rst_ld_done",  bus.ld_done_o, 1'b0);
    chk64("rst_ld_data",  bus.ld_data_o, 64'h0);
    chk1 ("rst_readEn",   bus.dmem_readEn, 1'b0);
    chk1 ("rst_writeEn",  bus.dmem_writeEn, 1'b0);
    chk64("rst_addrStore", bus.dmem_addressStore, 64'h0);

    // 1: load with empty queue goes to memory
    cyc(0, 0, 64'h0, 64'h0, 1, 64'h40);
    chk1 ("t1_readEn", bus.dmem_readEn, 1'b1);
    chk64("t1_addrLoad", bus.dmem_addressLoad, 64'h40);
    chk1 ("t1_writeEn", bus.dmem_writeEn, 1'b0);
    idle();
    chk1 ("t1_done", bus.ld_done_o, 1'b1);
    chk64("t1_data", bus.ld_data_o, 64'h1000_0000_0000_0040);
    chk1 ("t1_writeEn2", bus.dmem_writeEn, 1'b0);

    // 2: youngest of two matching stores forwards, older one drains in the load cycle
    cyc(0, 1, 64'h80, 64'hAA, 0, 64'h0);
    cyc(0, 1, 64'h80, 64'hBB, 1, 64'h48);
    chk1 ("t2_no_drain", bus.dmem_writeEn, 1'b0);
    cyc(0, 0, 64'h0, 64'h0, 1, 64'h80);
    chk1 ("t2_ld_ready", bus.ld_ready_o, 1'b1);
    chk1 ("t2_readEn", bus.dmem_readEn, 1'b0);
    chk1 ("t2_writeEn", bus.dmem_writeEn, 1'b1);
    chk64("t2_wdata", bus.dmem_WriteData, 64'hAA);
    idle();
    chk1 ("t2_done", bus.ld_done_o, 1'b1);
    chk64("t2_data", bus.ld_data_o, 64'hBB);
    chk64("t2_wdata2", bus.dmem_WriteData, 64'hBB);
    idle();

    // 3: fill the queue behind missing loads, then forced drain
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 64'h200 + 64'(8 * k), 64'hC0 + 64'(k), 1, 64'h300);
      chk1 ("t3_st_ready_fill", bus.st_ready_o, 1'b1);
    end
    cyc(0, 0, 64'h0, 64'h0, 1, 64'h300);
    chk1 ("t3_full_st_ready", bus.st_ready_o, 1'b0);
    chk1 ("t3_force_ld_ready", bus.ld_ready_o, 1'b0);
    chk1 ("t3_force_writeEn", bus.dmem_writeEn, 1'b1);
    chk64("t3_force_addr", bus.dmem_addressStore, 64'h200);
    cyc(0, 0, 64'h0, 64'h0, 1, 64'h300);
    chk1 ("t3_st_ready_back", bus.st_ready_o, 1'b1);
    chk1 ("t3_ld_ready_back", bus.ld_ready_o, 1'b1);
    repeat (4) idle();

    // 4: one store starved by missing loads for exactly MAX_WAIT cycles
    cyc(0, 1, 64'h500, 64'h77, 0, 64'h0);
    for (int k = 1; k <= MAX_WAIT; k++) begin
      cyc(0, 0, 64'h0, 64'h0, 1, 64'h600);
      chk1 ("t4_wait_ld_ready", bus.ld_ready_o, 1'b1);
      chk1 ("t4_wait_writeEn", bus.dmem_writeEn, 1'b0);
    end
    cyc(0, 0, 64'h0, 64'h0, 1, 64'h600);
    chk1 ("t4_force_ld_ready", bus.ld_ready_o, 1'b0);
    chk1 ("t4_force_writeEn", bus.dmem_writeEn, 1'b1);
    chk64("t4_force_addr", bus.dmem_addressStore, 64'h500);
    cyc(0, 0, 64'h0, 64'h0, 1, 64'h600);
    chk1 ("t4_after_ld_ready", bus.ld_ready_o, 1'b1);
    chk1 ("t4_after_writeEn", bus.dmem_writeEn, 1'b0);
    idle();

    // 5: same-cycle store is not forwarded
    cyc(0, 1, 64'h100, 64'h5555, 1, 64'h100);
    chk1 ("t5_readEn", bus.dmem_readEn, 1'b1);
    chk64("t5_addrLoad", bus.dmem_addressLoad, 64'h100);
    idle();
    chk64("t5_old_data", bus.ld_data_o, 64'h1000_0000_0000_0100);
    chk1 ("t5_drain", bus.dmem_writeEn, 1'b1);
    chk64("t5_drain_addr", bus.dmem_addressStore, 64'h100);
    cyc(0, 0, 64'h0, 64'h0, 1, 64'h100);
    chk1 ("t5_readEn2", bus.dmem_readEn, 1'b1);
    idle();
    chk64("t5_new_data", bus.ld_data_o, 64'h5555);

    // 6: reset discards queued stores and the in-flight load
    for (int k = 0; k < 3; k++)
      cyc(0, 1, 64'h700 + 64'(8 * k), 64'hE0 + 64'(k), 1, 64'h800);
    cyc(1, 0, 64'h0, 64'h0, 1, 64'h800);
    idle();
    chk1 ("t6_ld_done", bus.ld_done_o, 1'b0);
    chk1 ("t6_st_ready", bus.st_ready_o, 1'b1);
    chk1 ("t6_writeEn", bus.dmem_writeEn, 1'b0);
    chk64("t6_ld_data", bus.ld_data_o, 64'h0);
    idle();
    chk1 ("t6_writeEn2", bus.dmem_writeEn, 1'b0);

    // random traffic over a small address set so forwarding hits are common
    lv = 0;
    la = '0;
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 299) == 0);
      sv = ($urandom_range(0, 99) < 45);
      sa = 64'(8 * $urandom_range(0, 7));
      sd = {$urandom, $urandom};
      if (!(lv && !prev_rdy)) begin
        lv = ($urandom_range(0, 99) < 55);
        la = 64'(8 * $urandom_range(0, 7));
      end
      cyc(r, sv, sa, sd, lv, la);
      if (r) lv = 0;
    end
    repeat (12) idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
